// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of the SDRAM controller Avalon-MM slave.
// A registered grant selects one requester. The request signals of that port
// are muxed straight through to the controller. A small FIFO of port IDs
// records the issuer of every accepted read, so that readdatavalid can be
// routed back to the port that issued the read.
module sdram_port_arbiter #(
  parameter int ADDR_W   = 22,
  parameter int DATA_W   = 16,
  parameter int BE_W     = 2,
  parameter int MAX_PEND = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] s0_address,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writedata,
  input  logic [BE_W-1:0]   s0_byteenable,
  output logic              s0_waitrequest,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_readdatavalid,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  input  logic [BE_W-1:0]   s1_byteenable,
  output logic              s1_waitrequest,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic [BE_W-1:0]   m_byteenable,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  output logic              err_orphan_rdv
);

  // state | meaning
  // IDLE  | no grant, nothing driven to the controller
  // G0    | port 0 owns the controller slave
  // G1    | port 1 owns the controller slave
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PEND);

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic [MAX_PEND-1:0] id_mem;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic req0, req1, granted, sel, sel_read, sel_write;
  logic full, empty, read_blocked, accept, push, pop;

  assign req0       = s0_read | s0_write;
  assign req1       = s1_read | s1_write;
  assign granted    = (state_q != IDLE) && !reset_reset;
  assign sel        = (state_q == G1);
  assign sel_read   = sel ? s1_read  : s0_read;
  assign sel_write  = sel ? s1_write : s0_write;
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);

  // A granted read is held off while the ID FIFO is full; writes pass regardless.
  assign read_blocked = granted && sel_read && full;

  assign m_address    = sel ? s1_address    : s0_address;
  assign m_writedata  = sel ? s1_writedata  : s0_writedata;
  assign m_byteenable = sel ? s1_byteenable : s0_byteenable;
  assign m_read       = granted && sel_read && !full;
  assign m_write      = granted && sel_write;

  assign accept = (m_read || m_write) && !m_waitrequest;
  assign push   = accept && m_read;
  assign pop    = m_readdatavalid && !empty && !reset_reset;

  assign s0_readdata      = m_readdata;
  assign s1_readdata      = m_readdata;
  assign s0_readdatavalid = pop && !id_mem[rd_ptr];
  assign s1_readdatavalid = pop &&  id_mem[rd_ptr];

  // Stall every port except the granted one; the granted port sees the controller.
  always_comb begin
    s0_waitrequest = 1'b1;
    s1_waitrequest = 1'b1;
    if (granted && !sel) s0_waitrequest = m_waitrequest || read_blocked;
    if (granted &&  sel) s1_waitrequest = m_waitrequest || read_blocked;
  end

  // Grant selection and hand-over after each accepted transfer.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = rr_q ? G1 : G0;
        else if (req0)     state_d = G0;
        else if (req1)     state_d = G1;
      end
      G0: begin
        if (accept) begin
          rr_d    = 1'b1;
          state_d = req1 ? G1 : IDLE;
        end else if (!req0) begin
          state_d = IDLE;
        end
      end
      G1: begin
        if (accept) begin
          rr_d    = 1'b0;
          state_d = req0 ? G0 : IDLE;
        end else if (!req1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, round-robin pointer, FIFO pointers/occupancy and sticky orphan flag.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q        <= IDLE;
      rr_q           <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      err_orphan_rdv <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (m_readdatavalid && empty) err_orphan_rdv <= 1'b1;
    end
  end

  // Issuer ID storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk_clk) begin
    if (push) id_mem[wr_ptr] <= sel;
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a behavioural model
// (grant owner, round-robin pointer, queue of pending issuer IDs, orphan flag).
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 22, DATA_W = 16, BE_W = 2, MAX_PEND = 4;

  logic clk_clk = 1'b0;
  logic reset_reset;
  logic [ADDR_W-1:0] s0_address, s1_address, m_address;
  logic s0_read, s0_write, s1_read, s1_write;
  logic [DATA_W-1:0] s0_writedata, s1_writedata, m_writedata;
  logic [BE_W-1:0] s0_byteenable, s1_byteenable, m_byteenable;
  logic s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
  logic [DATA_W-1:0] s0_readdata, s1_readdata, m_readdata;
  logic m_read, m_write, m_waitrequest, m_readdatavalid, err_orphan_rdv;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_PEND(MAX_PEND)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
    .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .err_orphan_rdv(err_orphan_rdv));

  always #5 clk_clk = ~clk_clk;

  int n_vec = 0, n_err = 0;

  // model state
  int owner = -1;      // port holding the grant, -1 when none
  int rr_m = 0;
  int pend[$];         // issuer IDs of reads in flight, oldest first
  bit err_m = 0;
  bit acc_m, mr_m;
  int acc_port;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0;
    s0_address = '0; s1_address = '0; s0_writedata = '0; s1_writedata = '0;
    s0_byteenable = '0; s1_byteenable = '0;
    m_waitrequest = 0; m_readdatavalid = 0; m_readdata = '0;
  endtask

  // Evaluate outputs mid-cycle and compare against the model.
  task automatic settle();
    bit full, w0, w1, mw, v0, v1, rd, wr;
    @(negedge clk_clk);
    w0 = 1; w1 = 1; mr_m = 0; mw = 0; v0 = 0; v1 = 0;
    if (!reset_reset) begin
      full = (pend.size() >= MAX_PEND);
      if (owner >= 0) begin
        rd = (owner == 0) ? s0_read  : s1_read;
        wr = (owner == 0) ? s0_write : s1_write;
        mr_m = rd && !full;
        mw   = wr;
        if (owner == 0) w0 = (rd && full) ? 1'b1 : m_waitrequest;
        else            w1 = (rd && full) ? 1'b1 : m_waitrequest;
      end
      if (m_readdatavalid && pend.size() > 0) begin
        if (pend[0] == 0) v0 = 1; else v1 = 1;
      end
    end
    acc_m = !reset_reset && (mr_m || mw) && !m_waitrequest;
    chk("s0_waitrequest", s0_waitrequest, w0);
    chk("s1_waitrequest", s1_waitrequest, w1);
    chk("m_read", m_read, mr_m);
    chk("m_write", m_write, mw);
    chk("s0_readdatavalid", s0_readdatavalid, v0);
    chk("s1_readdatavalid", s1_readdatavalid, v1);
    chk("err_orphan_rdv", err_orphan_rdv, err_m);
    chk("s0_readdata", s0_readdata, m_readdata);
    chk("s1_readdata", s1_readdata, m_readdata);
    if (!reset_reset && owner >= 0) begin
      chk("m_address", m_address, (owner == 0) ? s0_address : s1_address);
      chk("m_writedata", m_writedata, (owner == 0) ? s0_writedata : s1_writedata);
      chk("m_byteenable", m_byteenable, (owner == 0) ? s0_byteenable : s1_byteenable);
    end
  endtask

  // Apply the clock-edge rules to the model, then move to the next cycle.
  task automatic advance();
    bit r0, r1;
    acc_port = -1;
    if (reset_reset) begin
      owner = -1; rr_m = 0; pend.delete(); err_m = 0;
    end else begin
      r0 = s0_read || s0_write;
      r1 = s1_read || s1_write;
      if (m_readdatavalid) begin
        if (pend.size() > 0) void'(pend.pop_front());
        else err_m = 1;
      end
      if (acc_m && mr_m) pend.push_back(owner);
      if (owner < 0) begin
        if (r0 && r1) owner = rr_m;
        else if (r0)  owner = 0;
        else if (r1)  owner = 1;
      end else if (acc_m) begin
        acc_port = owner;
        rr_m  = 1 - owner;
        owner = ((owner == 0) ? r1 : r0) ? 1 - owner : -1;
      end else if (!((owner == 0) ? r0 : r1)) begin
        owner = -1;
      end
    end
    @(posedge clk_clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_reset = 1;
    settle(); advance();
    reset_reset = 0;
  endtask

  bit act [2];

  initial begin
    idle_inputs();
    reset_reset = 1;
    @(posedge clk_clk); #1;

    // reset state
    settle();
    chk("rst_w0", s0_waitrequest, 1); chk("rst_w1", s1_waitrequest, 1);
    chk("rst_mread", m_read, 0); chk("rst_mwrite", m_write, 0);
    advance();
    settle();
    chk("rst_err", err_orphan_rdv, 0);
    advance();
    reset_reset = 0;

    // single write from port 0
    s0_write = 1; s0_address = 22'h000010; s0_writedata = 16'hBEEF; s0_byteenable = 2'b11;
    settle(); chk("t1_idle_mwrite", m_write, 0); advance();
    settle();
    chk("t1_mwrite", m_write, 1); chk("t1_addr", m_address, 32'h10);
    chk("t1_wdata", m_writedata, 32'hBEEF); chk("t1_w0", s0_waitrequest, 0);
    advance();
    s0_write = 0;
    settle(); chk("t1_back_idle", m_write, 0); chk("t1_w0_idle", s0_waitrequest, 1); advance();

    // both ports reading continuously alternate without idle gaps
    do_reset();
    s0_read = 1; s1_read = 1; m_readdatavalid = 1;
    settle(); advance();
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("t2_w0", s0_waitrequest, (k % 2) ? 1 : 0);
      chk("t2_w1", s1_waitrequest, (k % 2) ? 0 : 1);
      chk("t2_mread", m_read, 1);
      advance();
    end

    // read return routing, latency 3
    do_reset();
    s0_read = 1; s0_address = 22'h10; s1_read = 1; s1_address = 22'h20;
    settle(); advance();
    settle(); chk("t3_w0", s0_waitrequest, 0); chk("t3_a0", m_address, 32'h10); advance();
    s0_read = 0;
    settle(); chk("t3_w1", s1_waitrequest, 0); chk("t3_a1", m_address, 32'h20); advance();
    s1_read = 0;
    settle(); advance();
    m_readdatavalid = 1; m_readdata = 16'h1111;
    settle();
    chk("t3_v0", s0_readdatavalid, 1); chk("t3_v0_v1", s1_readdatavalid, 0);
    chk("t3_d0", s0_readdata, 32'h1111);
    advance();
    m_readdata = 16'h2222;
    settle();
    chk("t3_v1", s1_readdatavalid, 1); chk("t3_v1_v0", s0_readdatavalid, 0);
    chk("t3_d1", s1_readdata, 32'h2222);
    advance();
    m_readdatavalid = 0;

    // FIFO full holds the fifth read
    do_reset();
    s0_read = 1;
    repeat (9) begin settle(); advance(); end
    settle(); chk("t4_held_mread", m_read, 0); chk("t4_held_w0", s0_waitrequest, 1); advance();
    m_readdatavalid = 1;
    settle(); chk("t4_pop_v0", s0_readdatavalid, 1); chk("t4_pop_mread", m_read, 0); advance();
    m_readdatavalid = 0;
    settle(); chk("t4_issue_mread", m_read, 1); chk("t4_issue_w0", s0_waitrequest, 0); advance();
    s0_read = 0;

    // orphan readdatavalid
    do_reset();
    m_readdatavalid = 1;
    settle();
    chk("t5_v0", s0_readdatavalid, 0); chk("t5_v1", s1_readdatavalid, 0);
    chk("t5_err_before", err_orphan_rdv, 0);
    advance();
    m_readdatavalid = 0;
    settle(); chk("t5_err", err_orphan_rdv, 1); advance();

    // reset while G1 with two reads pending
    do_reset();
    s0_read = 1; s1_read = 1;
    settle(); advance();
    settle(); advance();
    s0_read = 0;
    settle(); advance();
    settle(); advance();
    m_waitrequest = 1;
    settle(); chk("t6_pend", pend.size(), 2); chk("t6_g1_w1", s1_waitrequest, 1); advance();
    reset_reset = 1;
    settle();
    chk("t6_rst_w0", s0_waitrequest, 1); chk("t6_rst_w1", s1_waitrequest, 1);
    chk("t6_rst_mread", m_read, 0);
    advance();
    reset_reset = 0; idle_inputs();
    settle(); chk("t6_idle_w1", s1_waitrequest, 1); chk("t6_err", err_orphan_rdv, 0); advance();
    m_readdatavalid = 1;
    settle(); chk("t6_late_v1", s1_readdatavalid, 0); advance();
    m_readdatavalid = 0;
    settle(); chk("t6_late_err", err_orphan_rdv, 1); advance();

    // random traffic
    do_reset();
    act[0] = 0; act[1] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      reset_reset = ($urandom_range(299) == 0);
      for (int i = 0; i < 2; i++) begin
        bit rd, wr;
        if (acc_port == i || reset_reset) act[i] = 0;
        else if (act[i] && $urandom_range(49) == 0) act[i] = 0;
        if (!act[i] && $urandom_range(2) == 0) begin
          act[i] = 1;
          rd = $urandom_range(1);
          wr = !rd;
          if (i == 0) begin
            s0_read = rd; s0_write = wr; s0_address = ADDR_W'($urandom);
            s0_writedata = DATA_W'($urandom); s0_byteenable = BE_W'($urandom);
          end else begin
            s1_read = rd; s1_write = wr; s1_address = ADDR_W'($urandom);
            s1_writedata = DATA_W'($urandom); s1_byteenable = BE_W'($urandom);
          end
        end
        if (!act[i]) begin
          if (i == 0) begin s0_read = 0; s0_write = 0; end
          else begin s1_read = 0; s1_write = 0; end
        end
      end
      m_waitrequest   = ($urandom_range(2) == 0);
      m_readdatavalid = ($urandom_range(3) == 0);
      m_readdata      = DATA_W'($urandom);
      settle(); advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
